// File: rtl/s27_bist_ctrl_pkg.sv
//==============================================================================
// bist_pkg: shared types, polynomial and LFSR step for the s27 BIST slice. Rev 1.0
//==============================================================================
`default_nettype none

package bist_pkg;

  localparam int                LFSR_W        = 8;
  localparam logic [LFSR_W-1:0] POLY_TAPS     = 8'hB8;
  localparam logic [LFSR_W-1:0] SEED_FALLBACK = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_FINISH  = 3'd5
  } bist_state_t;

  // Fibonacci shift-left step; din is XORed into the new LSB (MISR use).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                   input logic              din);
    return {q[LFSR_W-2:0], ^(q & POLY_TAPS)} ^ {{(LFSR_W-1){1'b0}}, din};
  endfunction

endpackage

`default_nettype wire

// File: rtl/s27_bist_ctrl_if.sv
//==============================================================================
// s27_bist_ctrl_if: scan/PI/result bundle between the BIST sequencer and core. Rev 1.0
//==============================================================================
`default_nettype none

interface s27_bist_ctrl_if;
  import bist_pkg::*;

  logic              START;
  logic              SE;
  logic              SI;
  logic              SO;
  logic [3:0]        PI;
  logic              PO;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic [LFSR_W-1:0] SIG;

  modport master (output START, SO, PO,
                  input  SE, SI, PI, BUSY, DONE, PASS, SIG);

  modport slave  (input  START, SO, PO,
                  output SE, SI, PI, BUSY, DONE, PASS, SIG);

endinterface

`default_nettype wire

// File: rtl/s27_bist_ctrl_lfsr8.sv
//==============================================================================
// lfsr8: 8-bit Fibonacci LFSR/MISR with parallel load and serial XOR-in. Rev 1.0
//==============================================================================
`default_nettype none

module lfsr8
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = 8'h00
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              en,
  input  wire logic              load,
  input  wire logic [LFSR_W-1:0] load_val,
  input  wire logic              din,
  output logic      [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_next(q, din);
    end
  end

endmodule

`default_nettype wire

// File: rtl/s27_bist_ctrl.sv
//==============================================================================
// s27_bist_ctrl: scan BIST sequencer (LFSR load, capture, unload into MISR, signature check). Rev 1.0
//==============================================================================
`default_nettype none

module s27_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                N_PATTERNS = 64,
  parameter int                CHAIN_LEN  = 3,
  parameter logic [LFSR_W-1:0] SEED       = 8'h01,
  parameter logic [LFSR_W-1:0] GOLDEN     = 8'h00
) (
  input  wire logic      CK,
  input  wire logic      RST,
  s27_bist_ctrl_if.slave bus
);

  localparam int                SC_W     = $clog2(CHAIN_LEN + 1);
  localparam int                PC_W     = $clog2(N_PATTERNS + 1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(N_PATTERNS - 1);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? SEED_FALLBACK : SEED;

  bist_state_t       state;
  logic [SC_W-1:0]   shift_cnt;
  logic [PC_W-1:0]   pat_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] misr;
  logic [LFSR_W-1:0] sig;
  logic              pass;
  logic              busy;
  logic              done;
  logic              session_go;
  logic              lfsr_en;
  logic              misr_en;
  logic              misr_din;

  assign session_go = (state == ST_IDLE) && bus.START;
  assign lfsr_en    = state inside {ST_LOAD, ST_SHIFT, ST_CAPTURE};
  // LOAD is excluded: the chain contents shifted out then are unknown.
  assign misr_en    = state inside {ST_CAPTURE, ST_SHIFT, ST_UNLOAD};
  assign misr_din   = (state == ST_CAPTURE) ? bus.PO : bus.SO;

  lfsr8 #(.RST_VAL(SEED_EFF)) u_lfsr (
    .clk      (CK),
    .rst      (RST),
    .en       (lfsr_en),
    .load     (session_go),
    .load_val (SEED_EFF),
    .din      (1'b0),
    .q        (lfsr)
  );

  lfsr8 #(.RST_VAL(8'h00)) u_misr (
    .clk      (CK),
    .rst      (RST),
    .en       (misr_en),
    .load     (session_go),
    .load_val (8'h00),
    .din      (misr_din),
    .q        (misr)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      sig       <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            sig       <= '0;
            pass      <= 1'b0;
          end
        end
        ST_LOAD, ST_SHIFT: begin
          if (shift_cnt == SC_LAST) begin
            shift_cnt <= '0;
            state     <= ST_CAPTURE;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          pat_cnt   <= pat_cnt + 1'b1;
          shift_cnt <= '0;
          state     <= (pat_cnt == PC_LAST) ? ST_UNLOAD : ST_SHIFT;
        end
        ST_UNLOAD: begin
          if (shift_cnt == SC_LAST) begin
            shift_cnt <= '0;
            state     <= ST_FINISH;
            done      <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          sig   <= misr;
          pass  <= (misr == GOLDEN);
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Same-cycle decode so the core samples these on the edge that advances us.
  assign bus.SE   = state inside {ST_LOAD, ST_SHIFT, ST_UNLOAD};
  assign bus.SI   = (state inside {ST_LOAD, ST_SHIFT}) ? lfsr[LFSR_W-1] : 1'b0;
  assign bus.PI   = (state == ST_CAPTURE) ? lfsr[3:0] : 4'h0;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.PASS = pass;
  assign bus.SIG  = sig;

endmodule

`default_nettype wire

// File: tb/tb_s27_bist_ctrl.sv
//==============================================================================
// tb_s27_bist_ctrl: directed/randomized bench with a cycle-schedule reference model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_s27_bist_ctrl;

  localparam int         NA     = 4;
  localparam int         CA     = 3;
  localparam logic [7:0] GOLD_A = 8'h00;
  localparam int         NB     = 1;
  localparam int         CB     = 3;
  localparam logic [7:0] GOLD_B = 8'h10;
  localparam int         TOT_A  = NA * (CA + 1) + CA + 1;
  localparam int         TOT_B  = NB * (CB + 1) + CB + 1;

  localparam int P_LOAD = 0, P_CAP = 1, P_SHIFT = 2, P_UNLOAD = 3, P_FIN = 4;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic rnd_so = 1'b0;
  logic rnd_po = 1'b0;
  int   core_mode = 1;
  int   checks = 0;
  int   errors = 0;

  always #5 CK = ~CK;

  s27_bist_ctrl_if bus_a ();
  s27_bist_ctrl_if bus_b ();

  s27_bist_ctrl #(.N_PATTERNS(NA), .CHAIN_LEN(CA), .SEED(8'h01), .GOLDEN(GOLD_A)) dut_a (
    .CK (CK), .RST (RST), .bus (bus_a.slave)
  );

  s27_bist_ctrl #(.N_PATTERNS(NB), .CHAIN_LEN(CB), .SEED(8'h00), .GOLDEN(GOLD_B)) dut_b (
    .CK (CK), .RST (RST), .bus (bus_b.slave)
  );

  // Behavioural s27 core; chain order SI -> G5 -> G6 -> G7 -> SO.
  logic g5 = 1'b0, g6 = 1'b0, g7 = 1'b0;
  logic g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
  assign g14 = ~bus_a.PI[0];
  assign g8  = g14 & g6;
  assign g12 = ~(bus_a.PI[1] | g7);
  assign g15 = g12 | g8;
  assign g16 = bus_a.PI[3] | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(g5 | g9);
  assign g10 = ~(g14 | g11);
  assign g13 = ~(bus_a.PI[2] | g12);
  assign g17 = ~g11;

  always @(posedge CK) begin
    if (bus_a.SE) begin
      g5 <= bus_a.SI; g6 <= g5; g7 <= g6;
    end else begin
      g5 <= g10; g6 <= g11; g7 <= g13;
    end
  end

  logic so_a, po_a;
  assign so_a = (core_mode == 0) ? g7 : (core_mode == 2) ? 1'b1 : (core_mode == 3) ? rnd_so : 1'b0;
  assign po_a = (core_mode == 0) ? g17 : (core_mode == 3) ? rnd_po : 1'b0;

  assign bus_a.START = start;
  assign bus_a.SO    = so_a;
  assign bus_a.PO    = po_a;
  assign bus_b.START = start;
  assign bus_b.SO    = 1'b0;
  assign bus_b.PO    = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] q, input logic d);
    logic fb;
    fb = q[7] ^ q[5] ^ q[4] ^ q[3];
    return {q[6:0], fb} ^ {7'b0, d};
  endfunction

  // Phase of busy cycle k, derived from the session schedule alone.
  function automatic int phase_of(input int k, input int n, input int c);
    int j;
    if (k < c) return P_LOAD;
    j = k - c;
    if (j < n * (c + 1)) begin
      if (j % (c + 1) == 0) return P_CAP;
      return (j / (c + 1) < n - 1) ? P_SHIFT : P_UNLOAD;
    end
    return P_FIN;
  endfunction

  task automatic check_cycle(input string who, input int ph, input logic [7:0] l,
                             input logic busy, input logic done, input logic se,
                             input logic si, input logic [3:0] pi);
    check({who, "_busy"}, 8'(busy), 8'h01);
    check({who, "_done"}, 8'(done), 8'(ph == P_FIN));
    check({who, "_se"}, 8'(se), 8'(ph == P_LOAD || ph == P_SHIFT || ph == P_UNLOAD));
    check({who, "_si"}, 8'(si), 8'((ph == P_LOAD || ph == P_SHIFT) ? l[7] : 1'b0));
    check({who, "_pi"}, 8'(pi), 8'((ph == P_CAP) ? l[3:0] : 4'h0));
  endtask

  task automatic run_session(input int mode, input int pulse_at, input int abort_at,
                             input bit hold, input bit chained, input bit chk_b,
                             output logic [7:0] sig_out);
    logic [7:0] la, ma, lb, mb;
    int ph, phb;
    core_mode = mode;
    la = 8'h01; ma = 8'h00; lb = 8'h01; mb = 8'h00; sig_out = 8'h00;
    if (!chained) begin
      @(negedge CK);
      start = 1'b1;
    end
    for (int k = 0; k <= TOT_A; k++) begin
      @(negedge CK);
      if (!hold) start = (k == pulse_at);
      rnd_so = 1'($urandom);
      rnd_po = 1'($urandom);
      #1;
      if (k == TOT_A) begin
        check("a_busy_end", 8'(bus_a.BUSY), 8'h00);
        check("a_done_end", 8'(bus_a.DONE), 8'h00);
        check("a_sig", bus_a.SIG, ma);
        check("a_pass", 8'(bus_a.PASS), 8'(ma == GOLD_A));
        sig_out = ma;
      end else begin
        ph = phase_of(k, NA, CA);
        check_cycle("a", ph, la, bus_a.BUSY, bus_a.DONE, bus_a.SE, bus_a.SI, bus_a.PI);
        if (ph == P_CAP) ma = step(ma, po_a);
        else if (ph == P_SHIFT || ph == P_UNLOAD) ma = step(ma, so_a);
        if (ph == P_LOAD || ph == P_SHIFT || ph == P_CAP) la = step(la, 1'b0);
      end
      if (chk_b) begin
        if (k < TOT_B) begin
          phb = phase_of(k, NB, CB);
          check_cycle("b", phb, lb, bus_b.BUSY, bus_b.DONE, bus_b.SE, bus_b.SI, bus_b.PI);
          if (phb == P_CAP || phb == P_SHIFT || phb == P_UNLOAD) mb = step(mb, 1'b0);
          if (phb == P_LOAD || phb == P_SHIFT || phb == P_CAP) lb = step(lb, 1'b0);
        end else if (k == TOT_B) begin
          check("b_busy_end", 8'(bus_b.BUSY), 8'h00);
          check("b_sig", bus_b.SIG, mb);
          check("b_pass", 8'(bus_b.PASS), 8'(mb == GOLD_B));
        end
      end
      if (k == abort_at) begin
        RST = 1'b1;
        @(negedge CK);
        #1;
        check("abort_busy", 8'(bus_a.BUSY), 8'h00);
        check("abort_done", 8'(bus_a.DONE), 8'h00);
        check("abort_se", 8'(bus_a.SE), 8'h00);
        check("abort_sig", bus_a.SIG, 8'h00);
        check("abort_pass", 8'(bus_a.PASS), 8'h00);
        RST = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] s, s_ref;

    // Reset, then idle with all outputs at their reset values.
    repeat (2) @(negedge CK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      #1;
      check("idle_se", 8'(bus_a.SE), 8'h00);
      check("idle_si", 8'(bus_a.SI), 8'h00);
      check("idle_pi", 8'(bus_a.PI), 8'h00);
      check("idle_busy", 8'(bus_a.BUSY), 8'h00);
      check("idle_done", 8'(bus_a.DONE), 8'h00);
      check("idle_sig", bus_a.SIG, 8'h00);
      check("idle_pass", 8'(bus_a.PASS), 8'h00);
    end

    // Quiet core: signature 00 matches GOLDEN on A, misses flipped GOLDEN on B.
    run_session(1, -1, -1, 1'b0, 1'b0, 1'b1, s);
    check("quiet_sig_zero", s, 8'h00);

    // SO stuck at 1 must leave a non-zero signature.
    run_session(2, -1, -1, 1'b0, 1'b0, 1'b0, s);
    checks++;
    assert (bus_a.SIG !== 8'h00) else begin
      errors++;
      $error("FAIL stuck_sig_nonzero observed=%0h expected=nonzero", bus_a.SIG);
    end

    // Random SO/PO streams.
    for (int r = 0; r < 3; r++) run_session(3, -1, -1, 1'b0, 1'b0, 1'b0, s);

    // s27 core attached: reference signature.
    run_session(0, -1, -1, 1'b0, 1'b0, 1'b0, s_ref);

    // START during SHIFT is ignored.
    run_session(0, 5, -1, 1'b0, 1'b0, 1'b0, s);
    check("pulse_sig", bus_a.SIG, s_ref);

    // Abort in cycle 7, then a fresh session reproduces the signature.
    run_session(0, -1, 7, 1'b0, 1'b0, 1'b0, s);
    run_session(0, -1, -1, 1'b0, 1'b0, 1'b0, s);
    check("restart_sig", bus_a.SIG, s_ref);

    // START held through FINISH restarts right after IDLE.
    run_session(1, -1, -1, 1'b1, 1'b0, 1'b0, s);
    run_session(0, -1, -1, 1'b0, 1'b1, 1'b0, s);
    check("chained_sig", bus_a.SIG, s_ref);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
